// File: rtl/scope_trigger_capture_if.sv
// Sample-path bundle: FWFT read side of the sample FIFO plus the framed output stream.
// master = capture stage, slave = FIFO/downstream side.
interface scope_trigger_capture_if #(
    parameter int DATA_W = 10
);
    logic              fifo_rd_en;
    logic              fifo_rd_vld;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              out_vld;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eof;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_vld,
        input  fifo_rd_data,
        output out_vld,
        input  out_ready,
        output out_data,
        output out_sof,
        output out_eof
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_vld,
        output fifo_rd_data,
        input  out_vld,
        output out_ready,
        input  out_data,
        input  out_sof,
        input  out_eof
    );
endinterface

// File: rtl/scope_trigger_capture.sv
// Trigger detector and frame capture behind the FWFT sample FIFO: drains while idle,
// arms on request, triggers on a hysteresis-qualified edge or timeout, emits one framed capture.
module scope_trigger_capture #(
    parameter int DATA_W = 10,
    parameter int LEN_W  = 13,
    parameter int TO_W   = 24
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   arm,
    input  logic                   trig_edge,
    input  logic                   trig_auto,
    input  logic [DATA_W-1:0]      trig_level,
    input  logic [DATA_W-1:0]      trig_hyst,
    input  logic [LEN_W-1:0]       frame_len,
    input  logic [TO_W-1:0]        auto_timeout,
    scope_trigger_capture_if.master bus,
    output logic                   busy,
    output logic                   trig_forced,
    output logic                   frame_done
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_edge;
    logic [DATA_W-1:0] r_level;
    logic [DATA_W-1:0] r_hyst;
    logic [TO_W-1:0]   r_timeout;
    logic [TO_W-1:0]   r_to_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_flag;
    logic              r_forced;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_sof;
    logic              r_out_eof;
    logic              r_frame_done;

    logic              w_pop;
    logic              w_accept;
    logic [DATA_W-1:0] w_sample;
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W:0]   w_hi_sum;
    logic              w_hi_sat;
    logic [DATA_W-1:0] w_hi;
    logic              w_set_cond;
    logic              w_hit;
    logic              w_set;
    logic              w_trig;
    logic              w_timeout;
    logic              w_eof_done;

    assign w_sample = bus.fifo_rd_data;
    assign w_pop    = bus.fifo_rd_en && bus.fifo_rd_vld;
    assign w_accept = r_out_vld && bus.out_ready;

    // Arming band edges, both saturating. A saturated upper edge still arms on a full-scale sample.
    assign w_lo     = (r_level > r_hyst) ? (r_level - r_hyst) : '0;
    assign w_hi_sum = {1'b0, r_level} + {1'b0, r_hyst};
    assign w_hi_sat = w_hi_sum[DATA_W] || (&w_hi_sum[DATA_W-1:0]);
    assign w_hi     = w_hi_sum[DATA_W] ? {DATA_W{1'b1}} : w_hi_sum[DATA_W-1:0];

    assign w_set_cond = r_edge ? (w_hi_sat ? (w_sample >= w_hi) : (w_sample > w_hi))
                               : (w_sample < w_lo);
    assign w_hit      = r_edge ? (w_sample <= r_level) : (w_sample >= r_level);

    assign w_trig     = (r_state == S_WAIT) && w_pop && r_flag && w_hit;
    assign w_set      = (r_state == S_WAIT) && w_pop && !r_flag && w_set_cond;
    assign w_timeout  = (r_state == S_WAIT) && trig_auto && (r_to_cnt == r_timeout) && !w_trig;
    assign w_eof_done = (r_state == S_CAP) && w_accept && r_out_eof;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_state_next = S_WAIT;
            S_WAIT:  if (w_trig || w_timeout) w_state_next = S_CAP;
            S_CAP:   if (w_eof_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_rd_en = 1'b0;
        busy           = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  bus.fifo_rd_en = !rd_rst;
            S_WAIT:  bus.fifo_rd_en = !rd_rst;
            S_CAP:   bus.fifo_rd_en = !rd_rst && (!r_out_vld || bus.out_ready) && (r_remaining != '0);
            default: bus.fifo_rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_edge       <= 1'b0;
            r_level      <= '0;
            r_hyst       <= '0;
            r_timeout    <= '0;
            r_to_cnt     <= '0;
            r_len        <= '0;
            r_remaining  <= '0;
            r_flag       <= 1'b0;
            r_forced     <= 1'b0;
            r_out_vld    <= 1'b0;
            r_out_data   <= '0;
            r_out_sof    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_eof_done;
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_edge    <= trig_edge;
                        r_level   <= trig_level;
                        r_hyst    <= trig_hyst;
                        r_timeout <= auto_timeout;
                        r_len     <= (frame_len == '0) ? LEN_W'(1) : frame_len;
                        r_flag    <= 1'b0;
                        r_to_cnt  <= '0;
                        r_forced  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (trig_auto) r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (w_set) r_flag <= 1'b1;
                    if (w_trig) begin
                        r_out_vld   <= 1'b1;
                        r_out_data  <= w_sample;
                        r_out_sof   <= 1'b1;
                        r_out_eof   <= (r_len == LEN_W'(1));
                        r_remaining <= r_len - LEN_W'(1);
                    end else if (w_timeout) begin
                        // Forced trigger: no sample owned yet, the next pop becomes sof.
                        r_forced    <= 1'b1;
                        r_remaining <= r_len;
                    end
                end
                S_CAP: begin
                    if (w_pop) begin
                        r_out_vld   <= 1'b1;
                        r_out_data  <= w_sample;
                        r_out_sof   <= (r_remaining == r_len);
                        r_out_eof   <= (r_remaining == LEN_W'(1));
                        r_remaining <= r_remaining - LEN_W'(1);
                    end else if (w_accept) begin
                        r_out_vld <= 1'b0;
                        r_out_sof <= 1'b0;
                        r_out_eof <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_vld  = r_out_vld;
    assign bus.out_data = r_out_data;
    assign bus.out_sof  = r_out_sof;
    assign bus.out_eof  = r_out_eof;
    assign trig_forced  = r_forced;
    assign frame_done   = r_frame_done;
endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: FWFT FIFO model feeding the DUT, beat collector on
// the output stream, one task per scenario.
module tb_scope_trigger_capture;
    localparam int DATA_W = 10;
    localparam int LEN_W  = 13;
    localparam int TO_W   = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              trig_edge;
    logic              trig_auto;
    logic [DATA_W-1:0] trig_level;
    logic [DATA_W-1:0] trig_hyst;
    logic [LEN_W-1:0]  frame_len;
    logic [TO_W-1:0]   auto_timeout;
    logic              busy;
    logic              trig_forced;
    logic              frame_done;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    scope_trigger_capture_if #(.DATA_W(DATA_W)) bus ();

    scope_trigger_capture #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
        .rd_clk       (clk),
        .rd_rst       (rst),
        .arm          (arm),
        .trig_edge    (trig_edge),
        .trig_auto    (trig_auto),
        .trig_level   (trig_level),
        .trig_hyst    (trig_hyst),
        .frame_len    (frame_len),
        .auto_timeout (auto_timeout),
        .bus          (bus),
        .busy         (busy),
        .trig_forced  (trig_forced),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model
    logic [DATA_W-1:0] fifo_mem [0:1023];
    logic [9:0]        wr_ptr = '0;
    logic [9:0]        rd_ptr = '0;
    assign bus.fifo_rd_vld  = (rd_ptr != wr_ptr);
    assign bus.fifo_rd_data = fifo_mem[rd_ptr];
    assign bus.out_ready    = out_ready;

    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en && bus.fifo_rd_vld) rd_ptr <= rd_ptr + 10'd1;
    end

    // Output stream collector, sampled mid-cycle
    logic [DATA_W-1:0] beat_data [0:255];
    logic              beat_sof  [0:255];
    logic              beat_eof  [0:255];
    int                n_beats = 0;
    int                done_cnt = 0;
    int                eof_cyc = 0;
    int                done_cyc = 0;
    int                rd_en_viol = 0;
    int                stable_viol = 0;
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    always @(negedge clk) begin
        if (bus.out_vld && bus.out_ready) begin
            beat_data[n_beats[7:0]] <= bus.out_data;
            beat_sof[n_beats[7:0]]  <= bus.out_sof;
            beat_eof[n_beats[7:0]]  <= bus.out_eof;
            n_beats <= n_beats + 1;
            if (bus.out_eof) eof_cyc <= cyc;
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (bus.out_vld && !bus.out_ready && bus.fifo_rd_en) rd_en_viol <= rd_en_viol + 1;
        if (stall_prev && (bus.out_data !== stall_data)) stable_viol <= stable_viol + 1;
        stall_prev <= bus.out_vld && !bus.out_ready;
        stall_data <= bus.out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        fifo_mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    task automatic do_arm(input logic e, input logic a, input int lvl, input int hys,
                          input int len, input int to);
        trig_edge    = e;
        trig_auto    = a;
        trig_level   = DATA_W'(lvl);
        trig_hyst    = DATA_W'(hys);
        frame_len    = LEN_W'(len);
        auto_timeout = TO_W'(to);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int max_cyc, input string name);
        int k = 0;
        while (done_cnt == d0 && k < max_cyc) begin
            tick();
            k++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s frame_done timeout got 0 pulses expected 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
        checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL rst_out_vld got %b expected 0", bus.out_vld); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data got %0d expected 0", bus.out_data); end
        checks++; if (bus.out_sof !== 1'b0 || bus.out_eof !== 1'b0) begin errors++; $display("FAIL rst_sof_eof got %b%b expected 00", bus.out_sof, bus.out_eof); end
        checks++; if (trig_forced !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b expected 00", trig_forced, frame_done); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b expected 0", bus.fifo_rd_en); end
        rst = 1'b0;
        tick();
        checks++; if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL idle_rd_en got %b expected 1", bus.fifo_rd_en); end
        $display("test_reset: done");
    endtask

    task automatic test_rising();
        logic [DATA_W-1:0] smp [7] = '{400, 500, 512, 513, 514, 515, 600};
        logic [DATA_W-1:0] exp [4] = '{512, 513, 514, 515};
        int base = n_beats;
        int d0 = done_cnt;
        int idx;
        out_ready = 1'b1;
        do_arm(1'b0, 1'b0, 512, 16, 4, 0);
        foreach (smp[i]) push(smp[i]);
        wait_done(d0, 100, "rise");
        tick();
        checks++; if (n_beats - base !== 4) begin errors++; $display("FAIL rise_beats got %0d expected 4", n_beats - base); end
        for (int i = 0; i < 4; i++) begin
            idx = base + i;
            checks++;
            if (beat_data[idx[7:0]] !== exp[i] || beat_sof[idx[7:0]] !== (i == 0) || beat_eof[idx[7:0]] !== (i == 3)) begin
                errors++;
                $display("FAIL rise_beat%0d got %0d sof%b eof%b expected %0d sof%b eof%b", i,
                         beat_data[idx[7:0]], beat_sof[idx[7:0]], beat_eof[idx[7:0]], exp[i], i == 0, i == 3);
            end
        end
        checks++; if (done_cyc !== eof_cyc + 1) begin errors++; $display("FAIL rise_done_lat got %0d expected %0d", done_cyc - eof_cyc, 1); end
        checks++; if (trig_forced !== 1'b0) begin errors++; $display("FAIL rise_forced got %b expected 0", trig_forced); end
        $display("test_rising: %0d beats", n_beats - base);
        ticks(5);
    endtask

    task automatic test_hyst();
        logic [DATA_W-1:0] s1 [4] = '{500, 520, 505, 530};
        logic [DATA_W-1:0] s2 [3] = '{490, 512, 513};
        int base = n_beats;
        int d0 = done_cnt;
        int idx;
        do_arm(1'b0, 1'b0, 512, 16, 2, 0);
        foreach (s1[i]) push(s1[i]);
        ticks(10);
        checks++; if (n_beats !== base || busy !== 1'b1) begin errors++; $display("FAIL hyst_reject got beats %0d busy %b expected 0 busy 1", n_beats - base, busy); end
        foreach (s2[i]) push(s2[i]);
        wait_done(d0, 100, "hyst");
        tick();
        checks++; if (n_beats - base !== 2) begin errors++; $display("FAIL hyst_beats got %0d expected 2", n_beats - base); end
        for (int i = 0; i < 2; i++) begin
            idx = base + i;
            checks++;
            if (beat_data[idx[7:0]] !== DATA_W'(512 + i) || beat_sof[idx[7:0]] !== (i == 0) || beat_eof[idx[7:0]] !== (i == 1)) begin
                errors++;
                $display("FAIL hyst_beat%0d got %0d expected %0d", i, beat_data[idx[7:0]], 512 + i);
            end
        end
        $display("test_hyst: %0d beats", n_beats - base);
        ticks(5);
    endtask

    task automatic test_auto();
        int base = n_beats;
        int d0 = done_cnt;
        int idx;
        do_arm(1'b0, 1'b1, 512, 16, 3, 10);
        for (int i = 0; i < 40; i++) push(10'd100);
        ticks(10);
        checks++; if (trig_forced !== 1'b0) begin errors++; $display("FAIL auto_early got %b expected 0", trig_forced); end
        tick();
        checks++; if (trig_forced !== 1'b1) begin errors++; $display("FAIL auto_fire got %b expected 1", trig_forced); end
        wait_done(d0, 100, "auto");
        tick();
        checks++; if (n_beats - base !== 3) begin errors++; $display("FAIL auto_beats got %0d expected 3", n_beats - base); end
        for (int i = 0; i < 3; i++) begin
            idx = base + i;
            checks++;
            if (beat_data[idx[7:0]] !== 10'd100 || beat_sof[idx[7:0]] !== (i == 0) || beat_eof[idx[7:0]] !== (i == 2)) begin
                errors++;
                $display("FAIL auto_beat%0d got %0d sof%b eof%b expected 100 sof%b eof%b", i,
                         beat_data[idx[7:0]], beat_sof[idx[7:0]], beat_eof[idx[7:0]], i == 0, i == 2);
            end
        end
        checks++; if (trig_forced !== 1'b1) begin errors++; $display("FAIL auto_hold got %b expected 1", trig_forced); end
        trig_auto = 1'b0;
        $display("test_auto: %0d beats forced=%b", n_beats - base, trig_forced);
        ticks(50);
    endtask

    task automatic test_backpressure();
        int base = n_beats;
        int d0 = done_cnt;
        int rv0 = rd_en_viol;
        int sv0 = stable_viol;
        int k = 0;
        int idx;
        do_arm(1'b0, 1'b0, 512, 16, 8, 0);
        push(10'd0);
        for (int i = 0; i < 8; i++) push(DATA_W'(512 + i));
        push(10'd900);
        while (done_cnt == d0 && k < 200) begin
            out_ready = ~out_ready;
            tick();
            k++;
        end
        out_ready = 1'b1;
        checks++; if (done_cnt == d0) begin errors++; $display("FAIL bp_done got 0 pulses expected 1"); end
        tick();
        checks++; if (n_beats - base !== 8) begin errors++; $display("FAIL bp_beats got %0d expected 8", n_beats - base); end
        for (int i = 0; i < 8; i++) begin
            idx = base + i;
            checks++;
            if (beat_data[idx[7:0]] !== DATA_W'(512 + i) || beat_sof[idx[7:0]] !== (i == 0) || beat_eof[idx[7:0]] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d got %0d expected %0d", i, beat_data[idx[7:0]], 512 + i);
            end
        end
        checks++; if (rd_en_viol - rv0 !== 0) begin errors++; $display("FAIL bp_rd_en got %0d stalled pops expected 0", rd_en_viol - rv0); end
        checks++; if (stable_viol - sv0 !== 0) begin errors++; $display("FAIL bp_stable got %0d changes expected 0", stable_viol - sv0); end
        $display("test_backpressure: %0d beats", n_beats - base);
        ticks(5);
    endtask

    task automatic test_len0();
        int base = n_beats;
        int d0 = done_cnt;
        do_arm(1'b0, 1'b0, 512, 16, 0, 0);
        push(10'd0);
        push(10'd600);
        push(10'd601);
        wait_done(d0, 100, "len0");
        tick();
        checks++; if (n_beats - base !== 1) begin errors++; $display("FAIL len0_beats got %0d expected 1", n_beats - base); end
        checks++;
        if (beat_data[base[7:0]] !== 10'd600 || beat_sof[base[7:0]] !== 1'b1 || beat_eof[base[7:0]] !== 1'b1) begin
            errors++;
            $display("FAIL len0_beat got %0d sof%b eof%b expected 600 sof1 eof1",
                     beat_data[base[7:0]], beat_sof[base[7:0]], beat_eof[base[7:0]]);
        end
        $display("test_len0: %0d beats", n_beats - base);
        ticks(5);
    endtask

    task automatic test_falling();
        logic [DATA_W-1:0] smp [5] = '{1000, 1023, 1021, 1020, 1019};
        logic [DATA_W-1:0] exp [2] = '{1020, 1019};
        int base = n_beats;
        int d0 = done_cnt;
        int idx;
        do_arm(1'b1, 1'b0, 1020, 10, 2, 0);
        foreach (smp[i]) push(smp[i]);
        wait_done(d0, 100, "fall");
        tick();
        checks++; if (n_beats - base !== 2) begin errors++; $display("FAIL fall_beats got %0d expected 2", n_beats - base); end
        for (int i = 0; i < 2; i++) begin
            idx = base + i;
            checks++;
            if (beat_data[idx[7:0]] !== exp[i] || beat_sof[idx[7:0]] !== (i == 0) || beat_eof[idx[7:0]] !== (i == 1)) begin
                errors++;
                $display("FAIL fall_beat%0d got %0d expected %0d", i, beat_data[idx[7:0]], exp[i]);
            end
        end
        $display("test_falling: %0d beats", n_beats - base);
        ticks(5);
    endtask

    task automatic test_arm_busy();
        logic [DATA_W-1:0] smp [4] = '{400, 512, 513, 514};
        int base = n_beats;
        int d0 = done_cnt;
        int idx;
        do_arm(1'b0, 1'b0, 512, 16, 2, 0);
        ticks(3);
        do_arm(1'b1, 1'b0, 100, 0, 5, 0);
        foreach (smp[i]) push(smp[i]);
        wait_done(d0, 100, "armbusy");
        tick();
        checks++; if (n_beats - base !== 2) begin errors++; $display("FAIL armbusy_beats got %0d expected 2", n_beats - base); end
        for (int i = 0; i < 2; i++) begin
            idx = base + i;
            checks++;
            if (beat_data[idx[7:0]] !== DATA_W'(512 + i)) begin
                errors++;
                $display("FAIL armbusy_beat%0d got %0d expected %0d", i, beat_data[idx[7:0]], 512 + i);
            end
        end
        $display("test_arm_busy: %0d beats", n_beats - base);
        ticks(5);
    endtask

    task automatic test_reset_mid();
        int base = n_beats;
        int d0 = done_cnt;
        int idx;
        do_arm(1'b0, 1'b0, 512, 16, 8, 0);
        push(10'd0);
        push(10'd512);
        push(10'd513);
        push(10'd514);
        ticks(20);
        checks++; if (n_beats - base !== 3 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got %0d beats busy %b expected 3 busy 1", n_beats - base, busy); end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.out_vld !== 1'b0 || bus.out_data !== '0 || bus.out_sof !== 1'b0 ||
            bus.out_eof !== 1'b0 || frame_done !== 1'b0 || trig_forced !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got busy%b vld%b data%0d sof%b eof%b done%b forced%b rd_en%b expected all 0",
                     busy, bus.out_vld, bus.out_data, bus.out_sof, bus.out_eof, frame_done, trig_forced, bus.fifo_rd_en);
        end
        rst = 1'b0;
        tick();
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mid_noeof got %0d pulses expected 0", done_cnt - d0); end
        base = n_beats;
        do_arm(1'b0, 1'b0, 512, 16, 2, 0);
        push(10'd0);
        push(10'd700);
        push(10'd701);
        wait_done(d0, 100, "mid_rearm");
        tick();
        checks++; if (n_beats - base !== 2) begin errors++; $display("FAIL mid_beats got %0d expected 2", n_beats - base); end
        for (int i = 0; i < 2; i++) begin
            idx = base + i;
            checks++;
            if (beat_data[idx[7:0]] !== DATA_W'(700 + i) || beat_sof[idx[7:0]] !== (i == 0) || beat_eof[idx[7:0]] !== (i == 1)) begin
                errors++;
                $display("FAIL mid_beat%0d got %0d expected %0d", i, beat_data[idx[7:0]], 700 + i);
            end
        end
        $display("test_reset_mid: %0d beats after rearm", n_beats - base);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) fifo_mem[i] = '0;
        arm          = 1'b0;
        trig_edge    = 1'b0;
        trig_auto    = 1'b0;
        trig_level   = '0;
        trig_hyst    = '0;
        frame_len    = '0;
        auto_timeout = '0;
        out_ready    = 1'b1;
        rst          = 1'b1;
        test_reset();
        test_rising();
        test_hyst();
        test_auto();
        test_backpressure();
        test_len0();
        test_falling();
        test_arm_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
